round_sequencer: RTL and testbench

Top-level scheduler for the permutation datapath. It drives a chain of stage units (rotate, parity, permute, etc.) in fixed order, one stage at a time, for a programmable number of rounds. Each stage unit exposes the standard start/Ready controller handshake. The block toggles the ping-pong memory bank after every stage, publishes the current round index for the round-constant stage, and pulses Done when the whole run completes.

---
 rtl/round_sequencer_if.sv | 28 ++
 rtl/round_sequencer.sv | 170 +++++++++++++++++
 tb/tb_round_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/round_sequencer_if.sv
// rtl/round_sequencer_if.sv - run request, stage handshake and status bundle for round_sequencer
interface round_sequencer_if #(
  parameter int NUM_STAGES = 5,
  parameter int SW         = 3,
  parameter int RW         = 5
);
  logic                  start;
  logic [RW-1:0]         rounds_in;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_start;
  logic [SW-1:0]         stage_idx;
  logic [RW-1:0]         round;
  logic                  bank_sel;
  logic                  Ready;
  logic                  Done;
  logic                  err;

  // master: the sequencer itself; slave: host plus the stage units
  modport master (
    input  start, rounds_in, stage_ready,
    output stage_start, stage_idx, round, bank_sel, Ready, Done, err
  );

  modport slave (
    output start, rounds_in, stage_ready,
    input  stage_start, stage_idx, round, bank_sel, Ready, Done, err
  );
endinterface

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - runs NUM_STAGES stage units in order for up to NUM_ROUNDS rounds
// Optional macro WATCHDOG_EN adds a WAIT-state timeout that sets a sticky err.
module round_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int SW         = 3,
  parameter int NUM_ROUNDS = 24,
  parameter int RW         = 5,
  parameter int TIMEOUT    = 1023
) (
  input logic               clk,
  input logic               reset,
  round_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ISSUE, S_ARM, S_WAIT, S_ADVANCE, S_FINISH
  } state_t;

  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
  localparam logic [RW-1:0] MAX_ROUNDS = RW'(NUM_ROUNDS);

  if (TIMEOUT < 1 || (1 << SW) < NUM_STAGES || (1 << RW) <= NUM_ROUNDS) begin : g_param_check
    $error("round_sequencer: inconsistent parameters");
  end

  state_t        state, state_nxt;
  logic [RW-1:0] lim;
  logic [RW-1:0] round_q;
  logic [SW-1:0] idx_q;
  logic          bank_q;
  logic [RW-1:0] rounds_clamped;
  logic [RW-1:0] round_inc;
  logic          idx_ready;
  logic          wd_expire;

  assign rounds_clamped = (bus.rounds_in > MAX_ROUNDS) ? MAX_ROUNDS : bus.rounds_in;
  assign round_inc      = round_q + 1'b1;
  assign idx_ready      = bus.stage_ready[idx_q];

  assign bus.stage_idx = idx_q;
  assign bus.round     = round_q;
  assign bus.bank_sel  = bank_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are Moore decodes so an async reset drops stage_start at once
  always_comb begin
    state_nxt       = state;
    bus.stage_start = '0;
    bus.Ready       = 1'b0;
    bus.Done        = 1'b0;
    case (state)
      S_IDLE: begin
        bus.Ready = 1'b1;
        if (bus.start) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nxt = (lim == '0) ? S_FINISH : S_ISSUE;
      end
      S_ISSUE: begin
        bus.stage_start[idx_q] = 1'b1;
        state_nxt              = S_ARM;
      end
      S_ARM: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (idx_ready) begin
          state_nxt = S_ADVANCE;
        end else if (wd_expire) begin
          state_nxt = S_IDLE;
        end
      end
      S_ADVANCE: begin
        if (idx_q != LAST_STAGE) begin
          state_nxt = S_ISSUE;
        end else if (round_inc == lim) begin
          state_nxt = S_FINISH;
        end else begin
          state_nxt = S_ISSUE;
        end
      end
      S_FINISH: begin
        bus.Done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lim     <= '0;
      idx_q   <= '0;
      round_q <= '0;
      bank_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lim <= rounds_clamped;
          end
        end
        S_LOAD: begin
          idx_q   <= '0;
          round_q <= '0;
          bank_q  <= 1'b0;
        end
        S_ADVANCE: begin
          bank_q <= ~bank_q;
          if (idx_q != LAST_STAGE) begin
            idx_q <= idx_q + 1'b1;
          end else begin
            idx_q   <= '0;
            round_q <= round_inc;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  logic [WDW-1:0] wd_cnt;
  logic           err_q;

  // wd_cnt holds the number of WAIT cycles already completed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == S_ARM) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign wd_expire = (state == S_WAIT) && !idx_ready && (wd_cnt == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state == S_LOAD) begin
      err_q <= 1'b0;
    end else if (wd_expire) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign wd_expire = 1'b0;
  assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - directed self-checking bench for round_sequencer
module tb_round_sequencer;
  localparam int NS   = 5;
  localparam int SW   = 3;
  localparam int NR   = 24;
  localparam int RW   = 5;
  localparam int TO   = 15;
  localparam int BUSY = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  round_sequencer_if #(.NUM_STAGES(NS), .SW(SW), .RW(RW)) bus ();

  round_sequencer #(
    .NUM_STAGES(NS), .SW(SW), .NUM_ROUNDS(NR), .RW(RW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  // Stub stage units: Ready drops on the start edge, returns after BUSY WAIT cycles
  logic [3:0]    busy_cnt [NS];
  logic [NS-1:0] unit_ready;
  logic [NS-1:0] stuck_mask = '0;
  logic          noise_en = 1'b0;
  logic [NS-1:0] noise_pat;
  logic [NS-1:0] sel_mask;

  for (genvar u = 0; u < NS; u++) begin : g_unit
    always @(posedge clk or posedge reset) begin
      if (reset) busy_cnt[u] <= 4'd0;
      else if (bus.stage_start[u]) busy_cnt[u] <= 4'(BUSY);
      else if (busy_cnt[u] != 4'd0) busy_cnt[u] <= busy_cnt[u] - 4'd1;
    end
    assign unit_ready[u] = (busy_cnt[u] == 4'd0) && !stuck_mask[u];
  end

  int cyc = 0;
  assign sel_mask  = NS'(1) << bus.stage_idx;
  assign noise_pat = NS'(cyc) ^ NS'(cyc >> 2);
  assign bus.stage_ready = unit_ready ^ (noise_en ? (noise_pat & ~sel_mask) : '0);

  int pulses = 0, order_bad = 0, done_cnt = 0, done_cyc = 0, round_sum = 0, exp_idx = 0;
  logic          bank_at_done = 1'b0;
  logic [RW-1:0] round_at_done = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.Ready) exp_idx <= 0;
    if (bus.stage_start != '0) begin
      pulses    <= pulses + 1;
      round_sum <= round_sum + int'(bus.round);
      if (bus.stage_start !== (NS'(1) << exp_idx) || int'(bus.stage_idx) != exp_idx)
        order_bad <= order_bad + 1;
      exp_idx <= (exp_idx == NS - 1) ? 0 : exp_idx + 1;
    end
    if (bus.Done) begin
      done_cnt      <= done_cnt + 1;
      done_cyc      <= cyc + 1;
      bank_at_done  <= bus.bank_sel;
      round_at_done <= bus.round;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic run(input int r, input bit hold, output int lat, output int npulse);
    int c0, d0, p0, n;
    p0 = pulses;
    d0 = done_cnt;
    c0 = cyc;
    bus.rounds_in = RW'(r);
    bus.start = 1'b1;
    tick();
    check("ready_low_in_load", 32'(bus.Ready), 0);
    if (!hold) bus.start = 1'b0;
    n = 0;
    while (done_cnt == d0 && n < 3000) begin
      tick();
      n++;
    end
    bus.start = 1'b0;
    check("done_seen", 32'(done_cnt - d0), 1);
    lat = done_cyc - c0;
    tick();
    tick();
    npulse = pulses - p0;
  endtask

  int lat, np, d0, p0, rs0, n, c0;

  initial begin
    bus.start = 1'b0;
    bus.rounds_in = '0;
    tick();
    tick();
    check("rst_ready", 32'(bus.Ready), 1);
    check("rst_stage_start", 32'(bus.stage_start), 0);
    check("rst_stage_idx", 32'(bus.stage_idx), 0);
    check("rst_round", 32'(bus.round), 0);
    check("rst_bank_sel", 32'(bus.bank_sel), 0);
    check("rst_done", 32'(bus.Done), 0);
    check("rst_err", 32'(bus.err), 0);
    reset = 1'b0;
    tick();

    // Full 24-round run
    run(24, 1'b0, lat, np);
    check("full_pulses", 32'(np), 120);
    check("full_latency", 32'(lat), 2 + 120 * 7);
    check("full_bank", 32'(bank_at_done), 0);
    check("full_round", 32'(round_at_done), 24);
    check("full_order", 32'(order_bad), 0);
    check("full_ready_back", 32'(bus.Ready), 1);
    check("full_err", 32'(bus.err), 0);

    // Single round: odd toggle count
    rs0 = round_sum;
    run(1, 1'b0, lat, np);
    check("one_pulses", 32'(np), 5);
    check("one_latency", 32'(lat), 2 + 5 * 7);
    check("one_bank", 32'(bank_at_done), 1);
    check("one_round_done", 32'(round_at_done), 1);
    check("one_round_steps", 32'(round_sum - rs0), 0);

    // Zero rounds and clamped request
    run(0, 1'b0, lat, np);
    check("zero_pulses", 32'(np), 0);
    check("zero_latency", 32'(lat), 2);
    check("zero_round", 32'(round_at_done), 0);
    run(31, 1'b0, lat, np);
    check("clamp_pulses", 32'(np), 120);
    check("clamp_round", 32'(round_at_done), 24);
    check("clamp_latency", 32'(lat), 2 + 120 * 7);

    // start held for the whole run with noisy foreign Ready bits
    noise_en = 1'b1;
    d0 = done_cnt;
    run(24, 1'b1, lat, np);
    check("hold_pulses", 32'(np), 120);
    check("hold_latency", 32'(lat), 2 + 120 * 7);
    for (int i = 0; i < 4; i++) tick();
    check("hold_single_run", 32'(done_cnt - d0), 1);
    check("hold_idle", 32'(bus.Ready), 1);
    check("hold_no_issue", 32'(bus.stage_start), 0);
    noise_en = 1'b0;
    check("hold_order", 32'(order_bad), 0);

    // Reset during WAIT of round 7 stage 2
    bus.rounds_in = RW'(24);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!(bus.round == RW'(7) && bus.stage_idx == SW'(2) && bus.stage_start[2]) && n < 2000) begin
      tick();
      n++;
    end
    check("reach_r7_s2", 32'(n < 2000), 1);
    tick();
    tick();
    check("mid_ready_low", 32'(bus.Ready), 0);
    check("mid_bank", 32'(bus.bank_sel), 1);
    reset = 1'b1;
    #1;
    check("async_stage_start", 32'(bus.stage_start), 0);
    check("async_ready", 32'(bus.Ready), 1);
    check("async_round", 32'(bus.round), 0);
    check("async_stage_idx", 32'(bus.stage_idx), 0);
    check("async_bank", 32'(bus.bank_sel), 0);
    check("async_done", 32'(bus.Done), 0);
    tick();
    reset = 1'b0;
    tick();
    run(24, 1'b0, lat, np);
    check("post_rst_pulses", 32'(np), 120);
    check("post_rst_latency", 32'(lat), 2 + 120 * 7);
    check("post_rst_bank", 32'(bank_at_done), 0);
    check("post_rst_order", 32'(order_bad), 0);

`ifdef WATCHDOG_EN
    // Unit 3 never returns Ready: abort after TO WAIT cycles
    stuck_mask = 5'b01000;
    d0 = done_cnt;
    p0 = pulses;
    c0 = cyc;
    bus.rounds_in = RW'(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    n = 0;
    while (!bus.Ready && n < 200) begin
      tick();
      n++;
    end
    check("wd_idle", 32'(bus.Ready), 1);
    check("wd_abort_cycle", 32'(cyc - c0), 1 + 3 * 7 + 2 + TO + 1);
    check("wd_err", 32'(bus.err), 1);
    check("wd_no_done", 32'(done_cnt - d0), 0);
    check("wd_pulses", 32'(pulses - p0), 4);
    stuck_mask = '0;
    tick();
    check("wd_err_sticky", 32'(bus.err), 1);
    bus.rounds_in = RW'(1);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    check("wd_err_cleared", 32'(bus.err), 0);
    n = 0;
    while (!bus.Ready && n < 200) begin
      tick();
      n++;
    end
    check("wd_rerun_done", 32'(done_cnt - d0), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
